// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the exception sequencer.
package exc_ctrl_pkg;

  localparam int unsigned EXC_W  = 5;
  localparam int unsigned VEC_W  = 9;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 3;

  // Exception codes written to CP0 Cause.ExcCode
  localparam logic [EXC_W-1:0] EXC_INT  = 5'h00;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'h05;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'h08;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'h09;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'h0A;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'h0C;
  localparam logic [EXC_W-1:0] EXC_TR   = 5'h0D;
  localparam logic [EXC_W-1:0] EXC_ERET = 5'h0E;

  // exc_vec bit positions, lowest index has highest priority
  localparam int unsigned BIT_ADEL_IF = 0;
  localparam int unsigned BIT_RI      = 1;
  localparam int unsigned BIT_SYS     = 2;
  localparam int unsigned BIT_BP      = 3;
  localparam int unsigned BIT_OV      = 4;
  localparam int unsigned BIT_TR      = 5;
  localparam int unsigned BIT_ADEL_D  = 6;
  localparam int unsigned BIT_ADES    = 7;
  localparam int unsigned BIT_ERET    = 8;

  // Exception vector constants
  localparam logic [ADDR_W-1:0] VEC_BOOT = 32'hBFC00380;
  localparam logic [11:0]       VEC_OFF  = 12'h180;

  // CP0 Status / Cause field positions
  localparam int unsigned ST_IE     = 0;
  localparam int unsigned ST_EXL    = 1;
  localparam int unsigned ST_IM_LO  = 8;
  localparam int unsigned ST_IM_HI  = 15;
  localparam int unsigned ST_BEV    = 22;
  localparam int unsigned CA_IP_LO  = 8;
  localparam int unsigned CA_IP_HI  = 15;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // Redirect target for a committed exception
  function automatic logic [ADDR_W-1:0] redirect_pc(
    input logic [EXC_W-1:0]  code,
    input logic [ADDR_W-1:0] epc,
    input logic              bev,
    input logic [ADDR_W-1:0] ebase
  );
    logic [ADDR_W-1:0] pc;
    if (code == EXC_ERET) begin
      pc = epc;
    end else if (bev) begin
      pc = VEC_BOOT;
    end else begin
      pc = {ebase[ADDR_W-1:12], VEC_OFF};
    end
    return pc;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Per-slot priority encoder: lowest set exc_vec bit selects the exception code.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic [8:0] i_vec,
  output logic [4:0] o_code,
  output logic       o_hit
);

  // Fixed-priority scan from bit 0 upward
  always_comb begin
    o_code = EXC_INT;
    o_hit  = |i_vec;
    if (i_vec[BIT_ADEL_IF]) begin
      o_code = EXC_ADEL;
    end else if (i_vec[BIT_RI]) begin
      o_code = EXC_RI;
    end else if (i_vec[BIT_SYS]) begin
      o_code = EXC_SYS;
    end else if (i_vec[BIT_BP]) begin
      o_code = EXC_BP;
    end else if (i_vec[BIT_OV]) begin
      o_code = EXC_OV;
    end else if (i_vec[BIT_TR]) begin
      o_code = EXC_TR;
    end else if (i_vec[BIT_ADEL_D]) begin
      o_code = EXC_ADEL;
    end else if (i_vec[BIT_ADES]) begin
      o_code = EXC_ADES;
    end else if (i_vec[BIT_ERET]) begin
      o_code = EXC_ERET;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: picks one exception per commit by age and priority,
// then drives the CP0 commit pulse, pipeline flush and PC redirect.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        valid_i1,
  input  logic        valid_i2,
  input  logic [8:0]  exc_vec_i1,
  input  logic [8:0]  exc_vec_i2,
  input  logic [31:0] inst_addr_i1,
  input  logic [31:0] inst_addr_i2,
  input  logic        in_delayslot_i1,
  input  logic        in_delayslot_i2,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] ebase_i,
  output logic        exception_flag_o,
  output logic [4:0]  excepttype_o,
  output logic        exception_inst_sel_o,
  output logic [31:0] inst_addr_o1,
  output logic [31:0] inst_addr_o2,
  output logic [31:0] mem_addr_o,
  output logic        in_delayslot_o1,
  output logic        in_delayslot_o2,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        new_pc_valid_o,
  output logic        busy_o
);

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_int_pend;

  logic               w_int_req;
  logic [EXC_W-1:0]   w_code1;
  logic [EXC_W-1:0]   w_code2;
  logic               w_hit1;
  logic               w_hit2;
  logic               w_sel_hit;
  logic               w_sel_slot1;
  logic [EXC_W-1:0]   w_sel_code;
  logic [ADDR_W-1:0]  w_sel_pc;
  logic               w_unused_bits;

  // Per-slot exception priority encoders
  exc_prio_enc u_enc1 (
    .i_vec  (exc_vec_i1),
    .o_code (w_code1),
    .o_hit  (w_hit1)
  );

  exc_prio_enc u_enc2 (
    .i_vec  (exc_vec_i2),
    .o_code (w_code2),
    .o_hit  (w_hit2)
  );

  // Unmasked, enabled interrupt request from current CP0 state
  assign w_int_req = status_i[ST_IE] & ~status_i[ST_EXL] &
                     (|(cause_i[CA_IP_HI:CA_IP_LO] & status_i[ST_IM_HI:ST_IM_LO]));

  // Interrupt is sampled every cycle so the commit never sees CP0 combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_pend <= 1'b0;
    end else begin
      r_int_pend <= w_int_req;
    end
  end

  // Age/priority selection: older slot first, interrupt outranks slot exceptions
  always_comb begin
    w_sel_hit   = 1'b0;
    w_sel_slot1 = 1'b0;
    w_sel_code  = EXC_INT;
    if (valid_i1 && (r_int_pend || w_hit1)) begin
      w_sel_hit   = 1'b1;
      w_sel_slot1 = 1'b1;
      w_sel_code  = r_int_pend ? EXC_INT : w_code1;
    end else if (valid_i2 && ((r_int_pend && !valid_i1) || (valid_i1 && w_hit2))) begin
      // Slot 2 faults only behind a clean slot 1, or takes an interrupt alone
      w_sel_hit   = 1'b1;
      w_sel_slot1 = 1'b0;
      w_sel_code  = r_int_pend ? EXC_INT : w_code2;
    end
  end

  // Redirect target for the selected exception
  assign w_sel_pc = redirect_pc(w_sel_code, epc_i, status_i[ST_BEV], ebase_i);

  // Fields of CP0 registers this block does not consume
  assign w_unused_bits = ^{status_i[31:23], status_i[21:16], status_i[7:2],
                           cause_i[31:16], cause_i[7:0], ebase_i[11:0]};

  // Commit/flush sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state              <= S_IDLE;
      r_cnt                <= '0;
      exception_flag_o     <= 1'b0;
      excepttype_o         <= '0;
      exception_inst_sel_o <= 1'b0;
      inst_addr_o1         <= '0;
      inst_addr_o2         <= '0;
      mem_addr_o           <= '0;
      in_delayslot_o1      <= 1'b0;
      in_delayslot_o2      <= 1'b0;
      flush_o              <= 1'b0;
      new_pc_o             <= '0;
      new_pc_valid_o       <= 1'b0;
      busy_o               <= 1'b0;
    end else begin
      exception_flag_o <= 1'b0;
      flush_o          <= 1'b0;
      new_pc_valid_o   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!stall_i && w_sel_hit) begin
            r_state              <= S_FLUSH;
            r_cnt                <= CNT_W'(1);
            exception_flag_o     <= 1'b1;
            flush_o              <= 1'b1;
            new_pc_valid_o       <= 1'b1;
            busy_o               <= 1'b1;
            excepttype_o         <= w_sel_code;
            exception_inst_sel_o <= w_sel_slot1;
            inst_addr_o1         <= inst_addr_i1;
            inst_addr_o2         <= inst_addr_i2;
            mem_addr_o           <= mem_addr_i;
            in_delayslot_o1      <= in_delayslot_i1;
            in_delayslot_o2      <= in_delayslot_i2;
            new_pc_o             <= w_sel_pc;
          end
        end
        S_FLUSH: begin
          if (r_cnt == FLUSH_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy_o  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: cycle model plus directed literal checks.
module tb_exc_ctrl;

  localparam int unsigned FC = 2;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        valid_i1, valid_i2;
  logic [8:0]  exc_vec_i1, exc_vec_i2;
  logic [31:0] inst_addr_i1, inst_addr_i2;
  logic        in_delayslot_i1, in_delayslot_i2;
  logic [31:0] mem_addr_i, status_i, cause_i, epc_i, ebase_i;
  logic        exception_flag_o;
  logic [4:0]  excepttype_o;
  logic        exception_inst_sel_o;
  logic [31:0] inst_addr_o1, inst_addr_o2, mem_addr_o;
  logic        in_delayslot_o1, in_delayslot_o2;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        new_pc_valid_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  exc_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_i              (stall_i),
    .valid_i1             (valid_i1),
    .valid_i2             (valid_i2),
    .exc_vec_i1           (exc_vec_i1),
    .exc_vec_i2           (exc_vec_i2),
    .inst_addr_i1         (inst_addr_i1),
    .inst_addr_i2         (inst_addr_i2),
    .in_delayslot_i1      (in_delayslot_i1),
    .in_delayslot_i2      (in_delayslot_i2),
    .mem_addr_i           (mem_addr_i),
    .status_i             (status_i),
    .cause_i              (cause_i),
    .epc_i                (epc_i),
    .ebase_i              (ebase_i),
    .exception_flag_o     (exception_flag_o),
    .excepttype_o         (excepttype_o),
    .exception_inst_sel_o (exception_inst_sel_o),
    .inst_addr_o1         (inst_addr_o1),
    .inst_addr_o2         (inst_addr_o2),
    .mem_addr_o           (mem_addr_o),
    .in_delayslot_o1      (in_delayslot_o1),
    .in_delayslot_o2      (in_delayslot_o2),
    .flush_o              (flush_o),
    .new_pc_o             (new_pc_o),
    .new_pc_valid_o       (new_pc_valid_o),
    .busy_o               (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0] code_tab [9];
  initial begin
    code_tab[0] = 5'h04; code_tab[1] = 5'h0A; code_tab[2] = 5'h08;
    code_tab[3] = 5'h09; code_tab[4] = 5'h0C; code_tab[5] = 5'h0D;
    code_tab[6] = 5'h04; code_tab[7] = 5'h05; code_tab[8] = 5'h0E;
  end

  function automatic logic [4:0] first_code(input logic [8:0] v);
    for (int b = 0; b < 9; b++) begin
      if (v[b]) return code_tab[b];
    end
    return 5'h00;
  endfunction

  bit          m_int;
  int          m_left;
  logic        m_flag, m_sel, m_ds1, m_ds2, m_busy;
  logic [4:0]  m_code;
  logic [31:0] m_a1, m_a2, m_ma, m_pc;

  always @(posedge clk) begin
    bit   take;
    bit   s1;
    logic [4:0] c;
    if (rst) begin
      m_int = 0; m_left = 0;
      m_flag = 0; m_sel = 0; m_ds1 = 0; m_ds2 = 0; m_busy = 0;
      m_code = 0; m_a1 = 0; m_a2 = 0; m_ma = 0; m_pc = 0;
    end else begin
      m_flag = 0;
      take = 0; s1 = 0; c = 0;
      if (m_left > 0) begin
        m_left--;
      end else if (!stall_i) begin
        if (valid_i1 && (m_int || exc_vec_i1 != 0)) begin
          take = 1; s1 = 1; c = m_int ? 5'h00 : first_code(exc_vec_i1);
        end else if (m_int && !valid_i1 && valid_i2) begin
          take = 1; s1 = 0; c = 5'h00;
        end else if (valid_i1 && exc_vec_i1 == 0 && valid_i2 && exc_vec_i2 != 0) begin
          take = 1; s1 = 0; c = first_code(exc_vec_i2);
        end
        if (take) begin
          m_flag = 1; m_sel = s1; m_code = c; m_left = FC;
          m_a1 = inst_addr_i1; m_a2 = inst_addr_i2; m_ma = mem_addr_i;
          m_ds1 = in_delayslot_i1; m_ds2 = in_delayslot_i2;
          if (c == 5'h0E) m_pc = epc_i;
          else if (status_i[22]) m_pc = 32'hBFC00380;
          else m_pc = (ebase_i & 32'hFFFF_F000) + 32'h180;
        end
      end
      m_busy = (m_left > 0);
      m_int = status_i[0] && !status_i[1] &&
              (((cause_i >> 8) & (status_i >> 8) & 32'hFF) != 0);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_flag",  32'(exception_flag_o),     32'(m_flag));
      chk("m_flush", 32'(flush_o),              32'(m_flag));
      chk("m_pcv",   32'(new_pc_valid_o),       32'(m_flag));
      chk("m_busy",  32'(busy_o),               32'(m_busy));
      chk("m_code",  32'(excepttype_o),         32'(m_code));
      chk("m_sel",   32'(exception_inst_sel_o), 32'(m_sel));
      chk("m_pc",    new_pc_o,                  m_pc);
      chk("m_a1",    inst_addr_o1,              m_a1);
      chk("m_a2",    inst_addr_o2,              m_a2);
      chk("m_ma",    mem_addr_o,                m_ma);
      chk("m_ds1",   32'(in_delayslot_o1),      32'(m_ds1));
      chk("m_ds2",   32'(in_delayslot_o2),      32'(m_ds2));
    end
  end

  task automatic clr();
    stall_i = 0; valid_i1 = 0; valid_i2 = 0;
    exc_vec_i1 = 0; exc_vec_i2 = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1; clr();
    inst_addr_i1 = 32'h0000_0400; inst_addr_i2 = 32'h0000_0404;
    in_delayslot_i1 = 0; in_delayslot_i2 = 0;
    mem_addr_i = 0; status_i = 0; cause_i = 0; epc_i = 0; ebase_i = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_flag", 32'(exception_flag_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_pc", new_pc_o, 32'd0);
    rst = 0;

    // RI beats Sys in slot 1, ebase-relative vector
    ebase_i = 32'h8000_1000; in_delayslot_i1 = 1;
    valid_i1 = 1; exc_vec_i1 = 9'h006;
    @(negedge clk); clr(); in_delayslot_i1 = 0;
    chk("t1_flag", 32'(exception_flag_o), 32'd1);
    chk("t1_code", 32'(excepttype_o), 32'h0A);
    chk("t1_sel", 32'(exception_inst_sel_o), 32'd1);
    chk("t1_pc", new_pc_o, 32'h8000_1180);
    chk("t1_ds1", 32'(in_delayslot_o1), 32'd1);
    @(negedge clk);
    chk("t1_pulse", 32'(exception_flag_o), 32'd0);
    chk("t1_busy2", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("t1_idle", 32'(busy_o), 32'd0);

    // AdES in slot 2 behind clean slot 1
    valid_i1 = 1; valid_i2 = 1; exc_vec_i2 = 9'h080; mem_addr_i = 32'h1003;
    @(negedge clk); clr();
    chk("t2_code", 32'(excepttype_o), 32'h05);
    chk("t2_sel", 32'(exception_inst_sel_o), 32'd0);
    chk("t2_ma", mem_addr_o, 32'h1003);
    repeat (2) @(negedge clk);

    // Flags on invalid slot 1 ignored; slot 2 not considered behind invalid slot 1
    valid_i1 = 0; exc_vec_i1 = 9'h004; valid_i2 = 1; exc_vec_i2 = 9'h002;
    @(negedge clk); clr();
    chk("ign_flag", 32'(exception_flag_o), 32'd0);

    // Interrupt pends with no valid slot, then binds to slot 1 over Ov
    status_i = 32'h0040_0401; cause_i = 32'h0000_0400;
    @(negedge clk);
    chk("t3_pend", 32'(exception_flag_o), 32'd0);
    valid_i1 = 1; exc_vec_i1 = 9'h010;
    @(negedge clk); clr(); cause_i = 0;
    chk("t3_flag", 32'(exception_flag_o), 32'd1);
    chk("t3_code", 32'(excepttype_o), 32'h00);
    chk("t3_sel", 32'(exception_inst_sel_o), 32'd1);
    chk("t3_pc", new_pc_o, 32'hBFC0_0380);
    repeat (2) @(negedge clk);
    status_i = 0;

    // ERET in slot 2; exception shown during FLUSH is dropped
    valid_i1 = 1; valid_i2 = 1; exc_vec_i2 = 9'h100; epc_i = 32'hBFC0_1234;
    @(negedge clk);
    chk("t4_flag", 32'(exception_flag_o), 32'd1);
    chk("t4_code", 32'(excepttype_o), 32'h0E);
    chk("t4_pc", new_pc_o, 32'hBFC0_1234);
    exc_vec_i2 = 0; valid_i2 = 0; exc_vec_i1 = 9'h001;
    @(negedge clk);
    @(negedge clk); clr();
    @(negedge clk);
    chk("t4_ignored", 32'(exception_flag_o), 32'd0);
    chk("t4_hold", 32'(excepttype_o), 32'h0E);

    // Stall holds off Bp for three cycles
    stall_i = 1; valid_i1 = 1; exc_vec_i1 = 9'h008;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_stalled", 32'(exception_flag_o), 32'd0);
    end
    stall_i = 0;
    @(negedge clk); clr();
    chk("t5_flag", 32'(exception_flag_o), 32'd1);
    chk("t5_code", 32'(excepttype_o), 32'h09);
    repeat (2) @(negedge clk);

    // Reset right after a commit, then a fresh exception is accepted
    valid_i1 = 1; exc_vec_i1 = 9'h020;
    @(negedge clk); clr();
    chk("t6_flag", 32'(exception_flag_o), 32'd1);
    chk("t6_code", 32'(excepttype_o), 32'h0D);
    rst = 1;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    chk("t6_rst_code", 32'(excepttype_o), 32'd0);
    chk("t6_rst_pc", new_pc_o, 32'd0);
    rst = 0; valid_i1 = 1; exc_vec_i1 = 9'h040;
    @(negedge clk); clr();
    chk("t6_new_flag", 32'(exception_flag_o), 32'd1);
    chk("t6_new_code", 32'(excepttype_o), 32'h04);
    chk("t6_new_pc", new_pc_o, 32'h8000_1180);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
